// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if
//   Box-request bus between the drawing clients and vga_plot_arbiter.
//   master : client side. It drives req and the per-requester box fields
//            req_x/req_y/req_w/req_h/req_colour, and receives gnt/done.
//   slave  : arbiter side (mirror of master).
//   Requester i owns slice i of every packed field.
interface vga_plot_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_x;
   logic [7*NREQ-1:0] req_y;
   logic [4*NREQ-1:0] req_w;
   logic [4*NREQ-1:0] req_h;
   logic [3*NREQ-1:0] req_colour;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;

   modport master (
      output req, req_x, req_y, req_w, req_h, req_colour,
      input  gnt, done
   );

   modport slave (
      input  req, req_x, req_y, req_w, req_h, req_colour,
      output gnt, done
   );
endinterface

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares the single vga_adapter pixel-write port among NREQ box-drawing
//   clients. Grants one client at a time (round-robin), then walks a w x h
//   filled rectangle in raster order, emitting one pixel per clock. Pixels
//   outside the XSCREEN x YSCREEN screen are suppressed but still take a cycle.
// Ports
//   CLOCK_50    : system clock
//   Resetn      : synchronous active-low reset
//   arb         : box-request bus (req, box fields in; gnt, done out)
//   busy        : high whenever the arbiter is not idle
//   vga_x/vga_y : pixel coordinate to vga_adapter (low bits of the sum)
//   vga_colour  : pixel colour to vga_adapter
//   vga_plot    : pixel write enable to vga_adapter
module vga_plot_arbiter #(
   parameter int NREQ    = 3,
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120
) (
   input  logic                 CLOCK_50,
   input  logic                 Resetn,
   vga_plot_arbiter_if.slave    arb,
   output logic                 busy,
   output logic [7:0]           vga_x,
   output logic [6:0]           vga_y,
   output logic [2:0]           vga_colour,
   output logic                 vga_plot
);

   localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [8:0] XLIM = 9'(XSCREEN);
   localparam logic [7:0] YLIM = 8'(YSCREEN);

   typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

   state_t          state;
   logic [RRW-1:0]  rr;      // last requester served
   logic [RRW-1:0]  gidx;    // requester currently granted
   logic [7:0]      cx;
   logic [6:0]      cy;
   logic [3:0]      cw;
   logic [3:0]      ch;
   logic [2:0]      ccol;
   logic [3:0]      xc;
   logic [3:0]      yc;
   logic [NREQ-1:0] gnt_r;
   logic [NREQ-1:0] done_r;

   // Round-robin search: first set req bit starting at rr+1, wrapping.
   logic            any_req;
   logic [RRW-1:0]  pick;
   logic [RRW-1:0]  cand;
   int unsigned     idx;

   always_comb begin
      any_req = 1'b0;
      pick    = '0;
      cand    = '0;
      idx     = 0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         idx  = (32'(rr) + i) % NREQ;
         cand = RRW'(idx);
         if (!any_req && arb.req[cand]) begin
            any_req = 1'b1;
            pick    = cand;
         end
      end
   end

   // Widened sums so off-screen boxes (e.g. x near 255) never wrap onto screen.
   logic [8:0] sx;
   logic [7:0] sy;

   always_comb begin
      sx = {1'b0, cx} + {5'd0, xc};
      sy = {1'b0, cy} + {4'd0, yc};
   end

   logic [3:0] pick_w;
   logic [3:0] pick_h;

   always_comb begin
      pick_w = arb.req_w[4*pick +: 4];
      pick_h = arb.req_h[4*pick +: 4];
   end

   // All outputs are registered from the state of the previous cycle, so the
   // pixel stream trails the DRAW state by one clock and done appears in the
   // IDLE cycle that follows FIN (gnt is still held during that cycle).
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         state      <= IDLE;
         rr         <= RRW'(NREQ - 1);
         gidx       <= '0;
         cx         <= '0;
         cy         <= '0;
         cw         <= '0;
         ch         <= '0;
         ccol       <= '0;
         xc         <= '0;
         yc         <= '0;
         gnt_r      <= '0;
         done_r     <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r   <= '0;
               vga_plot <= 1'b0;
               if (any_req) begin
                  gidx        <= pick;
                  cx          <= arb.req_x[8*pick +: 8];
                  cy          <= arb.req_y[7*pick +: 7];
                  cw          <= pick_w;
                  ch          <= pick_h;
                  ccol        <= arb.req_colour[3*pick +: 3];
                  xc          <= '0;
                  yc          <= '0;
                  gnt_r       <= '0;
                  gnt_r[pick] <= 1'b1;
                  state       <= ((pick_w == 4'd0) || (pick_h == 4'd0)) ? FIN : DRAW;
               end else begin
                  gnt_r <= '0;
               end
            end

            DRAW: begin
               vga_x      <= sx[7:0];
               vga_y      <= sy[6:0];
               vga_colour <= ccol;
               vga_plot   <= (sx < XLIM) && (sy < YLIM);
               if (xc == cw - 4'd1) begin
                  xc <= '0;
                  if (yc == ch - 4'd1) begin
                     state <= FIN;
                  end else begin
                     yc <= yc + 4'd1;
                  end
               end else begin
                  xc <= xc + 4'd1;
               end
            end

            FIN: begin
               vga_plot <= 1'b0;
               done_r   <= gnt_r;
               rr       <= gidx;
               state    <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign arb.gnt  = gnt_r;
   assign arb.done = done_r;
   assign busy     = (state != IDLE);

endmodule
